mem_responder: RTL and testbench

- Bus-side memory responder for the KS-10 CPU bus; it is the slave end of the memory-cycle handshake that the CPU's NXM bus monitor times out on.
- Decodes memory (non-IO) requests against the installed memory size and drives a synchronous SRAM port with configurable wait states.
- Returns a single-cycle bus ACK with read data.
- Out-of-range addresses are never acknowledged, so the CPU-side 15-cycle timeout raises NXM.

---
 rtl/mem_responder_if.sv | 24 ++
 rtl/mem_responder.sv | 108 ++++++++++
 tb/tb_mem_responder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// KS-10 CPU bus memory-cycle signals between the CPU (master) and a memory responder (slave).
interface mem_responder_if;
  logic        busREQI;
  logic [0:35] busADDRI;
  logic [0:35] busDATAI;
  logic        busACKO;
  logic [0:35] busDATAO;

  modport master (
    output busREQI,
    output busADDRI,
    output busDATAI,
    input  busACKO,
    input  busDATAO
  );

  modport slave (
    input  busREQI,
    input  busADDRI,
    input  busDATAI,
    output busACKO,
    output busDATAO
  );
endinterface

// File: rtl/mem_responder.sv
// KS-10 bus memory responder: decodes in-range memory cycles, runs a wait-stated SRAM access
// and returns a one-cycle ACK. Define MEM_RESP_DYNWS_EN to take wait states from port memWS.
module mem_responder #(
  parameter int unsigned MEM_WORDS   = 262144,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_responder_if.slave       bus,
  output logic [0:21]          sramADDR,
  output logic [0:35]          sramDATAO,
  input  logic [0:35]          sramDATAI,
  output logic                 sramRD,
  output logic                 sramWR
`ifdef MEM_RESP_DYNWS_EN
  ,
  input  logic [0:3]           memWS
`endif
);

  // Flag bit positions of the bus address word (bus.vh busREAD/busWRITE/busIO).
  localparam int unsigned BitRead  = 3;
  localparam int unsigned BitWrite = 5;
  localparam int unsigned BitIo    = 6;

  localparam logic [3:0]  MaxWs    = 4'd12;
  localparam logic [22:0] MemLimit = 23'(MEM_WORDS);

  typedef enum logic [1:0] {StIdle, StAccess, StAck, StTurn} stateType;

  stateType    state;
  logic [3:0]  waitCnt;
  logic        isRead;

  logic [0:21] reqAddr;
  logic        reqRead;
  logic        reqWrite;
  logic        reqIo;
  logic        reqOk;
  logic [3:0]  loadWs;
  logic        unusedAddr;

  assign reqAddr  = bus.busADDRI[14:35];
  assign reqRead  = bus.busADDRI[BitRead];
  assign reqWrite = bus.busADDRI[BitWrite];
  assign reqIo    = bus.busADDRI[BitIo];
  assign reqOk    = bus.busREQI && !reqIo && (reqRead || reqWrite)
                    && ({1'b0, reqAddr} < MemLimit);

  assign unusedAddr = ^{bus.busADDRI[0:2], bus.busADDRI[4], bus.busADDRI[7:13]};

`ifdef MEM_RESP_DYNWS_EN
  assign loadWs = (memWS > MaxWs) ? MaxWs : memWS;
`else
  assign loadWs = 4'(WAIT_STATES);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= StIdle;
      waitCnt      <= 4'd0;
      isRead       <= 1'b0;
      sramADDR     <= '0;
      sramDATAO    <= '0;
      sramRD       <= 1'b0;
      sramWR       <= 1'b0;
      bus.busACKO  <= 1'b0;
      bus.busDATAO <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (reqOk) begin
            // Read wins when both direction flags are set.
            sramADDR  <= reqAddr;
            sramDATAO <= bus.busDATAI;
            isRead    <= reqRead;
            sramRD    <= reqRead;
            sramWR    <= !reqRead;
            waitCnt   <= loadWs;
            state     <= StAccess;
          end
        end
        StAccess: begin
          if (waitCnt != 4'd0) begin
            waitCnt <= waitCnt - 4'd1;
          end else begin
            if (isRead) begin
              bus.busDATAO <= sramDATAI;
            end
            sramRD <= 1'b0;
            sramWR <= 1'b0;
            state  <= StAck;
          end
        end
        StAck: begin
          // ACK is registered out of this state, so the pulse covers the following cycle.
          bus.busACKO <= 1'b1;
          state       <= StTurn;
        end
        StTurn: begin
          bus.busACKO <= 1'b0;
          state       <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: timing, range decode, back-to-back, reset mid-access.
module tb_mem_responder;

  localparam int unsigned MemWords = 262144;

  logic        clk;
  logic        rst;
  logic [0:21] sramADDR;
  logic [0:35] sramDATAO;
  logic [0:35] sramDATAI;
  logic        sramRD;
  logic        sramWR;
  logic [0:35] sramWord;
  logic        useModel;
  logic [0:21] lastAddr;
  logic [0:35] lastData;
`ifdef MEM_RESP_DYNWS_EN
  logic [0:3]  memWS;
`endif

  int total;
  int bad;
  int ackCnt, rdCnt, wrCnt, ackFirst, ackSecond;
  logic [0:21] addrK0;
  logic [0:35] dataoK0;

  mem_responder_if bus ();

  mem_responder #(
    .MEM_WORDS  (MemWords),
    .WAIT_STATES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .sramADDR (sramADDR),
    .sramDATAO(sramDATAO),
    .sramDATAI(sramDATAI),
    .sramRD   (sramRD),
    .sramWR   (sramWR)
`ifdef MEM_RESP_DYNWS_EN
    ,
    .memWS    (memWS)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-word SRAM model: remembers the last write.
  always @(posedge clk) begin
    if (sramWR) begin
      lastAddr <= sramADDR;
      lastData <= sramDATAO;
    end
  end
  assign sramDATAI = useModel ? ((sramADDR == lastAddr) ? lastData : '0) : sramWord;

  function automatic logic [0:35] mk_addr(input logic rd, input logic wr, input logic io,
                                          input logic [0:21] pa);
    logic [0:35] a;
    a = '0;
    a[3] = rd;
    a[5] = wr;
    a[6] = io;
    a[14:35] = pa;
    return a;
  endfunction

  task automatic start_req(input logic rd, input logic wr, input logic io,
                           input logic [0:21] pa, input logic [0:35] wdata);
    @(negedge clk);
    bus.busADDRI = mk_addr(rd, wr, io, pa);
    bus.busDATAI = wdata;
    bus.busREQI  = 1'b1;
  endtask

  // Sample k is taken on the falling edge after rising edge N+k (N = acceptance edge).
  task automatic run_window(input int n, input int dropAt);
    ackCnt = 0; rdCnt = 0; wrCnt = 0; ackFirst = -1; ackSecond = -1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 0) begin
        addrK0  = sramADDR;
        dataoK0 = sramDATAO;
      end
      if (bus.busACKO) begin
        if (ackCnt == 0) ackFirst = k;
        else if (ackCnt == 1) ackSecond = k;
        ackCnt++;
      end
      if (sramRD) rdCnt++;
      if (sramWR) wrCnt++;
      if (k == dropAt) bus.busREQI = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2 rst = 1'b0;
    #4;
    total++; if (bus.busACKO !== 1'b0) begin bad++;
      $display("FAIL reset_ack: got %b want 0", bus.busACKO); end
    total++; if (bus.busDATAO !== 36'o0) begin bad++;
      $display("FAIL reset_datao: got %o want 0", bus.busDATAO); end
    total++; if (sramRD !== 1'b0 || sramWR !== 1'b0) begin bad++;
      $display("FAIL reset_strobes: got rd=%b wr=%b want 0 0", sramRD, sramWR); end
    total++; if (sramADDR !== 22'o0 || sramDATAO !== 36'o0) begin bad++;
      $display("FAIL reset_sram: got addr=%o data=%o want 0 0", sramADDR, sramDATAO); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_read;
    sramWord = 36'o123456701234;
    start_req(1'b1, 1'b0, 1'b0, 22'o100, 36'o0);
    run_window(10, 0);
    total++; if (rdCnt !== 3) begin bad++;
      $display("FAIL read_rd_cycles: got %0d want 3", rdCnt); end
    total++; if (wrCnt !== 0) begin bad++;
      $display("FAIL read_wr_cycles: got %0d want 0", wrCnt); end
    total++; if (ackCnt !== 1 || ackFirst !== 4) begin bad++;
      $display("FAIL read_ack: got count=%0d at=%0d want 1 at 4", ackCnt, ackFirst); end
    total++; if (addrK0 !== 22'o100) begin bad++;
      $display("FAIL read_addr: got %o want 100", addrK0); end
    total++; if (bus.busDATAO !== 36'o123456701234) begin bad++;
      $display("FAIL read_data: got %o want 123456701234", bus.busDATAO); end
  endtask

  task automatic test_write_top;
    start_req(1'b0, 1'b1, 1'b0, 22'(MemWords - 1), 36'o777777000000);
    run_window(10, 0);
    total++; if (wrCnt !== 3 || rdCnt !== 0) begin bad++;
      $display("FAIL write_strobes: got wr=%0d rd=%0d want 3 0", wrCnt, rdCnt); end
    total++; if (addrK0 !== 22'o777777) begin bad++;
      $display("FAIL write_addr: got %o want 777777", addrK0); end
    total++; if (dataoK0 !== 36'o777777000000) begin bad++;
      $display("FAIL write_data: got %o want 777777000000", dataoK0); end
    total++; if (ackCnt !== 1 || ackFirst !== 4) begin bad++;
      $display("FAIL write_ack: got count=%0d at=%0d want 1 at 4", ackCnt, ackFirst); end
    total++; if (bus.busDATAO !== 36'o123456701234) begin bad++;
      $display("FAIL write_keeps_datao: got %o want 123456701234", bus.busDATAO); end
    useModel = 1'b1;
    start_req(1'b1, 1'b0, 1'b0, 22'(MemWords - 1), 36'o0);
    run_window(10, 0);
    useModel = 1'b0;
    total++; if (ackCnt !== 1 || bus.busDATAO !== 36'o777777000000) begin bad++;
      $display("FAIL readback: got acks=%0d data=%o want 1 777777000000", ackCnt,
               bus.busDATAO); end
  endtask

  task automatic test_ignored;
    start_req(1'b1, 1'b0, 1'b0, 22'(MemWords), 36'o0);
    run_window(20, 19);
    total++; if (ackCnt !== 0 || rdCnt !== 0 || wrCnt !== 0) begin bad++;
      $display("FAIL out_of_range: got ack=%0d rd=%0d wr=%0d want 0 0 0", ackCnt, rdCnt, wrCnt);
    end
    start_req(1'b1, 1'b0, 1'b1, 22'o100, 36'o0);
    run_window(20, 19);
    total++; if (ackCnt !== 0 || rdCnt !== 0 || wrCnt !== 0) begin bad++;
      $display("FAIL io_cycle: got ack=%0d rd=%0d wr=%0d want 0 0 0", ackCnt, rdCnt, wrCnt);
    end
    start_req(1'b0, 1'b0, 1'b0, 22'o100, 36'o0);
    run_window(20, 19);
    total++; if (ackCnt !== 0 || rdCnt !== 0 || wrCnt !== 0) begin bad++;
      $display("FAIL no_direction: got ack=%0d rd=%0d wr=%0d want 0 0 0", ackCnt, rdCnt, wrCnt);
    end
  endtask

  task automatic test_back_to_back;
    sramWord = 36'o010203040506;
    start_req(1'b1, 1'b0, 1'b0, 22'o200, 36'o0);
    run_window(16, 11);
    total++; if (ackCnt !== 2) begin bad++;
      $display("FAIL b2b_count: got %0d want 2", ackCnt); end
    total++; if (ackFirst !== 4 || ackSecond !== 10) begin bad++;
      $display("FAIL b2b_spacing: got %0d,%0d want 4,10", ackFirst, ackSecond); end
    total++; if (rdCnt !== 6) begin bad++;
      $display("FAIL b2b_rd_cycles: got %0d want 6", rdCnt); end
  endtask

  task automatic test_reset_mid;
    sramWord = 36'o555555555555;
    start_req(1'b1, 1'b0, 1'b0, 22'o300, 36'o0);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    total++; if (sramRD !== 1'b1) begin bad++;
      $display("FAIL mid_pre_rd: got %b want 1", sramRD); end
    rst = 1'b0;
    #1;
    total++; if (sramRD !== 1'b0 || sramWR !== 1'b0 || bus.busACKO !== 1'b0) begin bad++;
      $display("FAIL mid_async: got rd=%b wr=%b ack=%b want 0 0 0", sramRD, sramWR,
               bus.busACKO); end
    bus.busREQI = 1'b0;
    run_window(8, -1);
    total++; if (ackCnt !== 0) begin bad++;
      $display("FAIL mid_no_ack: got %0d want 0", ackCnt); end
    rst = 1'b1;
    sramWord = 36'o765432101234;
    start_req(1'b1, 1'b0, 1'b0, 22'o100, 36'o0);
    run_window(10, 0);
    total++; if (ackCnt !== 1 || ackFirst !== 4) begin bad++;
      $display("FAIL mid_recover_ack: got count=%0d at=%0d want 1 at 4", ackCnt, ackFirst); end
    total++; if (bus.busDATAO !== 36'o765432101234) begin bad++;
      $display("FAIL mid_recover_data: got %o want 765432101234", bus.busDATAO); end
  endtask

`ifdef MEM_RESP_DYNWS_EN
  task automatic test_dynws;
    sramWord = 36'o111111111111;
    memWS = 4'd0;
    start_req(1'b1, 1'b0, 1'b0, 22'o100, 36'o0);
    run_window(8, 0);
    total++; if (ackCnt !== 1 || ackFirst !== 2 || rdCnt !== 1) begin bad++;
      $display("FAIL dynws_zero: got count=%0d at=%0d rd=%0d want 1 at 2 rd 1", ackCnt,
               ackFirst, rdCnt); end
    memWS = 4'd15;
    start_req(1'b1, 1'b0, 1'b0, 22'o100, 36'o0);
    run_window(20, 0);
    total++; if (ackCnt !== 1 || ackFirst !== 14 || rdCnt !== 13) begin bad++;
      $display("FAIL dynws_clamp: got count=%0d at=%0d rd=%0d want 1 at 14 rd 13", ackCnt,
               ackFirst, rdCnt); end
    memWS = 4'd2;
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    useModel = 1'b0;
    lastAddr = '1;
    lastData = '0;
    sramWord = '0;
    bus.busREQI = 1'b0;
    bus.busADDRI = '0;
    bus.busDATAI = '0;
`ifdef MEM_RESP_DYNWS_EN
    memWS = 4'd2;
`endif
    test_reset();
    test_read();
    test_write_top();
    test_ignored();
    test_back_to_back();
    test_reset_mid();
`ifdef MEM_RESP_DYNWS_EN
    test_dynws();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
